// File: rtl/sr_trace_buffer_pkg.sv
// Shared constants and types for the sr_cpu instruction trace buffer.
// Holds the NOP fill pattern, the FIFO full-mode encodings and the halt FSM states.
package sr_trace_buffer_pkg;

   localparam logic [31:0] TRACE_NOP = 32'h0000_0013;
   localparam logic MODE_CIRC = 1'b0;
   localparam logic MODE_STOP = 1'b1;

   typedef enum logic [1:0] {
      HALT_IDLE     = 2'd0,
      HALT_END_SEEN = 2'd1,
      HALT_DONE     = 2'd2
   } haltState_e;

endpackage

// File: rtl/sr_trace_buffer_fifo.sv
// Show-ahead trace FIFO with overwrite-oldest or drop-newest behaviour when full.
// Head data reads as zero while empty so the reader never sees stale entries.
module sr_trace_fifo
   import sr_trace_buffer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             wrEn,
   input  logic [WIDTH-1:0] wrData,
   input  logic             mode,
   input  logic             rdReady,
   output logic             rdValid,
   output logic [WIDTH-1:0] rdData,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [CNT_W-1:0] countQ;
   logic [CNT_W-1:0] countNext;
   logic             overflowQ;
   logic             full;
   logic             pop;
   logic             doWrite;
   logic             advRd;
   logic             setOvf;

   assign rdValid  = (countQ != '0);
   assign full     = (countQ == CNT_W'(DEPTH));
   assign pop      = rdValid & rdReady;
   assign count    = countQ;
   assign overflow = overflowQ;
   assign rdData   = rdValid ? mem[rdPtr] : '0;

   // A full FIFO only loses data when nothing is popped in the same cycle.
   always_comb begin
      doWrite   = 1'b0;
      advRd     = pop;
      setOvf    = 1'b0;
      countNext = countQ;
      if (wrEn) begin
         if (!full || pop) begin
            doWrite = 1'b1;
            if (!pop) countNext = countQ + 1'b1;
         end else if (mode == MODE_CIRC) begin
            doWrite = 1'b1;
            advRd   = 1'b1;
            setOvf  = 1'b1;
         end else begin
            setOvf = 1'b1;
         end
      end else if (pop) begin
         countNext = countQ - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         countQ    <= '0;
         overflowQ <= 1'b0;
      end else if (clear) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         countQ    <= '0;
         overflowQ <= 1'b0;
      end else begin
         if (doWrite) wrPtr <= wrPtr + 1'b1;
         if (advRd) rdPtr <= rdPtr + 1'b1;
         countQ <= countNext;
         if (setOvf) overflowQ <= 1'b1;
      end
   end

   // Storage needs no reset: rdData is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (doWrite) mem[wrPtr] <= wrData;
   end

endmodule

// File: rtl/sr_trace_buffer.sv
// Fetch-stage instruction trace for sr_cpu: cycle stamping, capture qualification,
// end-of-program detection (second invalid fetch) and a sticky cycle timeout.
module sr_trace_buffer
   import sr_trace_buffer_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 16,
   parameter int CYC_W   = 16,
   parameter int TIMEOUT = 7000,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              trc_en_i,
   input  logic              mode_i,
   input  logic              freeze_i,
   input  logic              pc_valid_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              instr_valid_i,
   input  logic [31:0]       instr_i,
   output logic              rd_valid_o,
   input  logic              rd_ready_i,
   output logic [CYC_W-1:0]  rd_cycle_o,
   output logic [ADDR_W-1:0] rd_pc_o,
   output logic [31:0]       rd_instr_o,
   output logic              rd_inv_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              overflow_o,
   output logic              done_o,
   output logic              timeout_o
);

   localparam int ENTRY_W = CYC_W + ADDR_W + 32 + 1;
   localparam logic [CYC_W-1:0] CYC_MAX     = '1;
   localparam logic [CYC_W-1:0] TIMEOUT_VAL = CYC_W'(TIMEOUT);

   logic [CYC_W-1:0]   cycleCnt;
   logic [CYC_W-1:0]   cycleNext;
   logic               cycleInc;
   logic               timeoutQ;
   logic               cap;
   logic [ENTRY_W-1:0] wrData;
   logic [ENTRY_W-1:0] rdData;
   haltState_e         haltState;
   haltState_e         haltNext;

   assign done_o    = (haltState == HALT_DONE);
   assign timeout_o = timeoutQ;
   assign cap       = trc_en_i & pc_valid_i & ~freeze_i & ~done_o & ~timeoutQ;
   assign cycleInc  = trc_en_i & (cycleCnt != CYC_MAX);
   assign cycleNext = cycleCnt + 1'b1;
   assign wrData    = {cycleCnt, pc_i, (instr_valid_i ? instr_i : TRACE_NOP), ~instr_valid_i};
   assign {rd_cycle_o, rd_pc_o, rd_instr_o, rd_inv_o} = rdData;

   // Saturating stamp counter; the timeout fires on the step that lands on TIMEOUT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycleCnt <= '0;
         timeoutQ <= 1'b0;
      end else if (clear_i) begin
         cycleCnt <= '0;
         timeoutQ <= 1'b0;
      end else if (cycleInc) begin
         cycleCnt <= cycleNext;
         if (cycleNext == TIMEOUT_VAL) timeoutQ <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) haltState <= HALT_IDLE;
      else if (clear_i) haltState <= HALT_IDLE;
      else haltState <= haltNext;
   end

   // Only captured invalid fetches advance the halt FSM; the two need not be adjacent.
   always_comb begin
      haltNext = haltState;
      if (cap && !instr_valid_i) begin
         case (haltState)
            HALT_IDLE:     haltNext = HALT_END_SEEN;
            HALT_END_SEEN: haltNext = HALT_DONE;
            default:       haltNext = haltState;
         endcase
      end
   end

   sr_trace_fifo #(
      .WIDTH(ENTRY_W),
      .DEPTH(DEPTH)
   ) uFifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear_i),
      .wrEn    (cap),
      .wrData  (wrData),
      .mode    (mode_i),
      .rdReady (rd_ready_i),
      .rdValid (rd_valid_o),
      .rdData  (rdData),
      .count   (count_o),
      .overflow(overflow_o)
   );

endmodule

// File: tb/tb_sr_trace_buffer.sv
// Self-checking bench for sr_trace_buffer: directed scenarios plus random streams
// compared every cycle against a queue-based reference model.
module tb_sr_trace_buffer;

   localparam int ADDR_W  = 32;
   localparam int DEPTH   = 16;
   localparam int CYC_W   = 10;
   localparam int TIMEOUT = 300;
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int CYC_MAX = (1 << CYC_W) - 1;

   typedef struct {
      logic [CYC_W-1:0] stamp;
      logic [31:0]      pc;
      logic [31:0]      instr;
      logic             inv;
   } entry_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clear_i, trc_en_i, mode_i, freeze_i, pc_valid_i;
   logic [ADDR_W-1:0] pc_i;
   logic              instr_valid_i;
   logic [31:0]       instr_i;
   logic              rd_valid_o, rd_ready_i;
   logic [CYC_W-1:0]  rd_cycle_o;
   logic [ADDR_W-1:0] rd_pc_o;
   logic [31:0]       rd_instr_o;
   logic              rd_inv_o;
   logic [CNT_W-1:0]  count_o;
   logic              overflow_o, done_o, timeout_o;

   int total = 0;
   int bad = 0;

   entry_t q[$];
   int     mCnt;
   bit     mEnd, mDone, mTo, mOvf;

   sr_trace_buffer #(
      .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CYC_W(CYC_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .trc_en_i(trc_en_i),
      .mode_i(mode_i), .freeze_i(freeze_i), .pc_valid_i(pc_valid_i), .pc_i(pc_i),
      .instr_valid_i(instr_valid_i), .instr_i(instr_i), .rd_valid_o(rd_valid_o),
      .rd_ready_i(rd_ready_i), .rd_cycle_o(rd_cycle_o), .rd_pc_o(rd_pc_o),
      .rd_instr_o(rd_instr_o), .rd_inv_o(rd_inv_o), .count_o(count_o),
      .overflow_o(overflow_o), .done_o(done_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   task automatic checkValue(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      assert (act === exp) else begin
         bad++;
         $error("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic modelReset();
      q.delete();
      mCnt = 0; mEnd = 0; mDone = 0; mTo = 0; mOvf = 0;
   endtask

   // Reference behaviour for one rising edge, from the inputs present before it.
   task automatic modelStep(input bit clr, input bit en, input bit md, input bit frz, input bit pcv,
                            input logic [31:0] pc, input bit iv, input logic [31:0] ins, input bit rdy);
      bit cap, pop;
      int sz;
      entry_t e;
      if (clr) begin
         modelReset();
         return;
      end
      sz  = q.size();
      pop = (sz != 0) && rdy;
      cap = en && pcv && !frz && !mDone && !mTo;
      if (cap) begin
         e.stamp = mCnt[CYC_W-1:0];
         e.pc    = pc;
         e.instr = iv ? ins : 32'h0000_0013;
         e.inv   = !iv;
         if (!iv) begin
            if (mEnd) mDone = 1;
            else mEnd = 1;
         end
      end
      if (pop) void'(q.pop_front());
      if (cap) begin
         if (sz == DEPTH && !pop) begin
            if (!md) begin
               void'(q.pop_front());
               q.push_back(e);
            end
            mOvf = 1;
         end else begin
            q.push_back(e);
         end
      end
      if (en && mCnt < CYC_MAX) begin
         mCnt++;
         if (mCnt == TIMEOUT) mTo = 1;
      end
   endtask

   task automatic checkOutput();
      bit hv;
      hv = (q.size() != 0);
      checkValue("rd_valid", rd_valid_o, hv);
      checkValue("count", count_o, q.size());
      checkValue("overflow", overflow_o, mOvf);
      checkValue("done", done_o, mDone);
      checkValue("timeout", timeout_o, mTo);
      checkValue("rd_cycle", rd_cycle_o, hv ? q[0].stamp : '0);
      checkValue("rd_pc", rd_pc_o, hv ? q[0].pc : '0);
      checkValue("rd_instr", rd_instr_o, hv ? q[0].instr : '0);
      checkValue("rd_inv", rd_inv_o, hv ? q[0].inv : 1'b0);
   endtask

   task automatic applyStimulus(input bit clr, input bit en, input bit md, input bit frz, input bit pcv,
                                input logic [31:0] pc, input bit iv, input logic [31:0] ins, input bit rdy);
      clear_i = clr; trc_en_i = en; mode_i = md; freeze_i = frz; pc_valid_i = pcv;
      pc_i = pc; instr_valid_i = iv; instr_i = ins; rd_ready_i = rdy;
      modelStep(clr, en, md, frz, pcv, pc, iv, ins, rdy);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic doClear();
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic capture(input bit md, input logic [31:0] pc, input bit iv);
      applyStimulus(0, 1, md, 0, 1, pc, iv, 32'hA000_0000 | pc, 0);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
   endtask

   // md=2 picks the full-mode at random each cycle.
   task automatic runRandom(input int n, input int md, input int invPct);
      for (int i = 0; i < n; i++) begin
         applyStimulus(0, $urandom_range(0, 7) != 0,
                       (md == 2) ? bit'($urandom_range(0, 1)) : bit'(md),
                       $urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0, $urandom,
                       $urandom_range(0, 99) >= invPct, $urandom, $urandom_range(0, 2) == 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clear_i = 0; trc_en_i = 0; mode_i = 0; freeze_i = 0; pc_valid_i = 0;
      pc_i = 0; instr_valid_i = 1; instr_i = 0; rd_ready_i = 0;
      modelReset();
      #12;
      checkOutput();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // In-order capture then drain, stamps 0..3.
      doClear();
      for (int k = 0; k < 4; k++) capture(0, 32'(4 * k), 1);
      checkValue("s2_count", count_o, 4);
      checkValue("s2_head_stamp", rd_cycle_o, 0);
      drain(4);
      checkValue("s2_empty", rd_valid_o, 0);

      // Circular overwrite of the oldest four.
      doClear();
      for (int k = 0; k < 20; k++) capture(0, 32'(4 * k), 1);
      checkValue("s3_count", count_o, DEPTH);
      checkValue("s3_ovf", overflow_o, 1);
      checkValue("s3_head_pc", rd_pc_o, 32'h10);
      checkValue("s3_head_stamp", rd_cycle_o, 4);
      drain(DEPTH);

      // Stop-when-full keeps the first sixteen.
      doClear();
      for (int k = 0; k < 20; k++) capture(1, 32'(4 * k), 1);
      checkValue("s4_count", count_o, DEPTH);
      checkValue("s4_ovf", overflow_o, 1);
      checkValue("s4_head_pc", rd_pc_o, 32'h0);
      drain(DEPTH - 1);
      checkValue("s4_last_pc", rd_pc_o, 32'h3C);
      drain(1);

      // Freeze: invalid fetches presented while frozen must not reach the halt FSM.
      doClear();
      capture(0, 32'h100, 1);
      capture(0, 32'h104, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 1, 32'h108, 0, 0, 0);
      capture(0, 32'h108, 1);
      checkValue("s5_done", done_o, 0);
      checkValue("s5_count", count_o, 3);
      drain(2);
      checkValue("s5_stamp_skip", rd_cycle_o, 5);
      drain(1);

      // Halt on the second (non-adjacent) invalid fetch.
      doClear();
      capture(0, 32'h20, 0);
      capture(0, 32'h24, 1);
      capture(0, 32'h28, 1);
      capture(0, 32'h30, 0);
      checkValue("s6_done", done_o, 1);
      capture(0, 32'h34, 1);
      capture(0, 32'h38, 0);
      checkValue("s6_count", count_o, 4);
      checkValue("s6_head_nop", rd_instr_o, 32'h13);
      checkValue("s6_head_inv", rd_inv_o, 1);
      drain(4);

      // Asynchronous reset mid-trace with count 5 and done set.
      doClear();
      for (int k = 0; k < 3; k++) capture(0, 32'(4 * k), 1);
      capture(0, 32'h40, 0);
      capture(0, 32'h44, 0);
      checkValue("s1_pre_count", count_o, 5);
      checkValue("s1_pre_done", done_o, 1);
      rst_n = 1'b0;
      #2;
      modelReset();
      checkOutput();
      #1 rst_n = 1'b1;
      capture(0, 32'h80, 1);
      checkValue("s1_restamp", rd_cycle_o, 0);
      drain(1);

      // Random streams, including mid-trace mode changes.
      doClear();
      runRandom(150, 0, 3);
      drain(DEPTH);
      doClear();
      runRandom(150, 1, 3);
      drain(DEPTH);
      doClear();
      runRandom(150, 2, 2);
      drain(DEPTH);

      // Timeout with no halt: capture stops, FIFO stays drainable.
      doClear();
      for (int i = 0; i < TIMEOUT + 5; i++)
         applyStimulus(0, 1, 0, 0, 1, 32'(4 * i), 1, $urandom, $urandom_range(0, 1) == 1);
      checkValue("s6b_timeout", timeout_o, 1);
      drain(DEPTH);
      checkValue("s6b_drained", count_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
